// File: rtl/ofifo_row.sv
// Row-aligning output FIFO behind the mac_col array: one private lane per column,
// rows released only when every lane holds at least one psum.
module ofifo_row #(
   parameter int col     = 8,
   parameter int bw_psum = 19,
   parameter int depth   = 16,
   parameter int ptr_w   = $clog2(depth)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [col-1:0]           wr,
   input  logic [col*bw_psum-1:0]   in,
   input  logic                     rd,
   output logic [col*bw_psum-1:0]   out,
   output logic                     out_vld,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_ready,
   output logic                     o_err
);

   localparam int cnt_w = ptr_w + 1;

   logic [bw_psum-1:0] mem [col][depth];
   logic [ptr_w-1:0]   wptr [col];
   logic [ptr_w-1:0]   rptr [col];
   logic [cnt_w-1:0]   cnt  [col];

   logic [col-1:0] full;
   logic [col-1:0] empty;
   logic [col-1:0] push_ok;
   logic           pop_ok;
   logic           overflow;
   logic           underflow;

   always_comb begin
      full  = '0;
      empty = '0;
      for (int j = 0; j < col; j++) begin
         full[j]  = (cnt[j] == cnt_w'(depth));
         empty[j] = (cnt[j] == '0);
      end
   end

   assign o_valid   = ~|empty;
   assign o_full    = |full;
   assign o_ready   = ~o_full;

   // A push into a full lane is dropped even if the row pops on the same edge.
   assign push_ok   = wr & ~full;
   assign pop_ok    = rd & o_valid;
   assign overflow  = |(wr & full);
   assign underflow = rd & ~o_valid;

   // Storage array is not reset; occupancy counters alone decide what is live.
   always_ff @(posedge clk) begin
      for (int j = 0; j < col; j++) begin
         if (push_ok[j]) begin
            mem[j][wptr[j]] <= in[j*bw_psum +: bw_psum];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < col; j++) begin
            wptr[j] <= '0;
            rptr[j] <= '0;
            cnt[j]  <= '0;
         end
      end else begin
         for (int j = 0; j < col; j++) begin
            if (push_ok[j]) begin
               wptr[j] <= wptr[j] + 1'b1;
            end
            if (pop_ok) begin
               rptr[j] <= rptr[j] + 1'b1;
            end
            cnt[j] <= cnt[j] + cnt_w'(push_ok[j]) - cnt_w'(pop_ok);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out     <= '0;
         out_vld <= 1'b0;
      end else begin
         out_vld <= pop_ok;
         if (pop_ok) begin
            for (int j = 0; j < col; j++) begin
               out[j*bw_psum +: bw_psum] <= mem[j][rptr[j]];
            end
         end
      end
   end

   // Sticky error: cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_err <= 1'b0;
      end else if (overflow || underflow) begin
         o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ofifo_row.sv
// Directed self-checking bench for ofifo_row: staggered pushes, fill, wrap,
// underflow, overflow with simultaneous pop, and mid-operation reset.
module tb_ofifo_row;

   localparam int COL = 8;
   localparam int BW  = 19;
   localparam int W   = COL * BW;

   logic           clk;
   logic           reset;
   logic [COL-1:0] wr;
   logic [W-1:0]   in;
   logic           rd;
   logic [W-1:0]   out;
   logic           out_vld;
   logic           o_valid;
   logic           o_full;
   logic           o_ready;
   logic           o_err;

   int tests_run;
   int tests_failed;

   ofifo_row #(.col(COL), .bw_psum(BW), .depth(16), .ptr_w(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .in      (in),
      .rd      (rd),
      .out     (out),
      .out_vld (out_vld),
      .o_valid (o_valid),
      .o_full  (o_full),
      .o_ready (o_ready),
      .o_err   (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Row whose lane j holds base+j.
   function automatic logic [W-1:0] mk_row(input int base);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < COL; j++) begin
         r[j*BW +: BW] = BW'(base + j);
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr    = '0;
      rd    = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset = 1'b0;
      wr    = '0;
      in    = '0;
      rd    = 1'b0;

      // Test 1: reset values and staggered pushes
      do_reset();
      check("rst_out", out, '0);
      check("rst_out_vld", W'(out_vld), W'(0));
      check("rst_err", W'(o_err), W'(0));
      check("rst_valid", W'(o_valid), W'(0));
      check("rst_full", W'(o_full), W'(0));
      check("rst_ready", W'(o_ready), W'(1));
      in = mk_row(100);
      for (int j = 0; j < COL; j++) begin
         wr = COL'(1) << j;
         step();
         check($sformatf("stagger_valid_%0d", j), W'(o_valid), W'(j == COL - 1));
      end
      wr = '0;
      rd = 1'b1;
      step();
      rd = 1'b0;
      check("t1_out", out, mk_row(100));
      check("t1_out_vld", W'(out_vld), W'(1));
      check("t1_valid_after", W'(o_valid), W'(0));
      step();
      check("t1_vld_drop", W'(out_vld), W'(0));
      check("t1_out_hold", out, mk_row(100));

      // Test 2: fill to depth, overflow, drain
      for (int k = 0; k < 16; k++) begin
         wr = '1;
         in = mk_row(16 * k);
         step();
      end
      check("t2_full", W'(o_full), W'(1));
      check("t2_ready", W'(o_ready), W'(0));
      check("t2_err_pre", W'(o_err), W'(0));
      in = mk_row(7000);
      step();
      wr = '0;
      check("t2_err_ovf", W'(o_err), W'(1));
      check("t2_full_hold", W'(o_full), W'(1));
      rd = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         check($sformatf("t2_pop_%0d", k), out, mk_row(16 * k));
         check($sformatf("t2_vld_%0d", k), W'(out_vld), W'(1));
      end
      rd = 1'b0;
      check("t2_empty", W'(o_valid), W'(0));
      step();
      check("t2_vld_end", W'(out_vld), W'(0));

      // Test 3: wrap-around with continuous push and pop
      do_reset();
      wr = '1;
      in = mk_row(1000);
      step();
      for (int i = 1; i < 40; i++) begin
         wr = '1;
         in = mk_row(1000 + 8 * i);
         rd = 1'b1;
         step();
         check($sformatf("t3_row_%0d", i - 1), out, mk_row(1000 + 8 * (i - 1)));
      end
      wr = '0;
      step();
      rd = 1'b0;
      check("t3_row_39", out, mk_row(1000 + 8 * 39));
      check("t3_vld", W'(out_vld), W'(1));
      check("t3_err", W'(o_err), W'(0));
      check("t3_empty", W'(o_valid), W'(0));

      // Test 4: underflow
      do_reset();
      rd = 1'b1;
      step();
      rd = 1'b0;
      check("t4_out", out, '0);
      check("t4_vld", W'(out_vld), W'(0));
      check("t4_err", W'(o_err), W'(1));
      step();
      step();
      check("t4_err_sticky", W'(o_err), W'(1));

      // Test 5: pop and push together on full lanes
      do_reset();
      for (int k = 0; k < 16; k++) begin
         wr = '1;
         in = mk_row(2000 + 8 * k);
         step();
      end
      check("t5_full", W'(o_full), W'(1));
      wr = '1;
      in = mk_row(9000);
      rd = 1'b1;
      step();
      wr = '0;
      check("t5_out", out, mk_row(2000));
      check("t5_vld", W'(out_vld), W'(1));
      check("t5_err", W'(o_err), W'(1));
      check("t5_full_after", W'(o_full), W'(0));
      check("t5_ready_after", W'(o_ready), W'(1));
      for (int k = 1; k < 16; k++) begin
         step();
         check($sformatf("t5_pop_%0d", k), out, mk_row(2000 + 8 * k));
      end
      rd = 1'b0;
      check("t5_empty", W'(o_valid), W'(0));

      // Test 6: reset mid-operation
      do_reset();
      rd = 1'b1;
      step();
      rd = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wr = '1;
         in = mk_row(3000 + 8 * k);
         step();
      end
      wr = '0;
      rd = 1'b1;
      step();
      rd = 1'b0;
      check("t6_pre_out", out, mk_row(3000));
      check("t6_pre_err", W'(o_err), W'(1));
      do_reset();
      check("t6_valid", W'(o_valid), W'(0));
      check("t6_full", W'(o_full), W'(0));
      check("t6_out", out, '0);
      check("t6_vld", W'(out_vld), W'(0));
      check("t6_err", W'(o_err), W'(0));
      wr = '1;
      in = mk_row(4000);
      step();
      wr = '0;
      rd = 1'b1;
      step();
      rd = 1'b0;
      check("t6_post_out", out, mk_row(4000));
      check("t6_post_vld", W'(out_vld), W'(1));
      check("t6_post_empty", W'(o_valid), W'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
